// File: rtl/sba_pkg.sv
// Shared types, error codes and sizing helper for the system-bus-access master.
package sba_pkg;

    typedef enum logic [1:0] {
        SBA_IDLE = 2'd0,
        SBA_REQ  = 2'd1,
        SBA_WAIT = 2'd2
    } sba_state_e;

    localparam logic [2:0] SBERR_NONE    = 3'd0;
    localparam logic [2:0] SBERR_TIMEOUT = 3'd1;
    localparam logic [2:0] SBERR_BADADDR = 3'd2;
    localparam logic [2:0] SBERR_ALIGN   = 3'd3;
    localparam logic [2:0] SBERR_SIZE    = 3'd4;

    // Largest legal sbaccess value (log2 of bus width in bytes).
    function automatic logic [2:0] sba_max_size(input int data_width);
        logic [2:0] max_s;
        case (data_width)
            32'd32:  max_s = 3'd2;
            32'd64:  max_s = 3'd3;
            32'd128: max_s = 3'd4;
            default: max_s = 3'd2;
        endcase
        return max_s;
    endfunction

endpackage

// File: rtl/sba_lane_align.sv
// Byte-lane steering: byte enables and write-data replication for the request,
// right-aligned zero-extended extraction for the read response.
module sba_lane_align #(
    parameter int  DATA_WIDTH = 64,
    localparam int BE_W       = DATA_WIDTH / 8,
    localparam int OFF_W      = $clog2(BE_W)
) (
    input  logic [OFF_W-1:0]      req_off_i,
    input  logic [2:0]            req_size_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [BE_W-1:0]       be_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    input  logic [OFF_W-1:0]      rsp_off_i,
    input  logic [2:0]            rsp_size_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [7:0] req_bytes_s;
    logic [7:0] rsp_bytes_s;

    assign req_bytes_s = 8'd1 << req_size_i;
    assign rsp_bytes_s = 8'd1 << rsp_size_i;

    // A shift by the full vector width yields zero, so the full-width access
    // naturally produces an all-ones mask.
    assign be_o    = ~({BE_W{1'b1}} << req_bytes_s) << req_off_i;
    assign rdata_o = (rdata_i >> {rsp_off_i, 3'b000})
                   & ~({DATA_WIDTH{1'b1}} << {rsp_bytes_s, 3'b000});

    // Replicate the low 2^size bytes by repeated doubling until the bus is full.
    always_comb begin
        wdata_o = wdata_i & ~({DATA_WIDTH{1'b1}} << {req_bytes_s, 3'b000});
        for (int k = 0; k < OFF_W; k++) begin
            if (k >= int'(req_size_i)) begin
                wdata_o = wdata_o | (wdata_o << (32'd8 << k));
            end else begin
                wdata_o = wdata_o;
            end
        end
    end

endmodule

// File: rtl/sba_bus_master.sv
// Debug-module system bus access master: turns SBA triggers into single-beat
// request/grant/response transactions with error reporting and timeout.
module sba_bus_master
    import sba_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    dmactive_i,
    input  logic [ADDR_WIDTH-1:0]   sbaddress_i,
    input  logic                    sbaddress_write_valid_i,
    input  logic                    sbreadonaddr_i,
    input  logic                    sbreadondata_i,
    input  logic                    sbautoincrement_i,
    input  logic [2:0]              sbaccess_i,
    input  logic [DATA_WIDTH-1:0]   sbdata_i,
    input  logic                    sbdata_write_valid_i,
    input  logic                    sbdata_read_valid_i,
    input  logic [2:0]              sberror_clear_i,
    input  logic                    sbbusyerror_clear_i,
    output logic [ADDR_WIDTH-1:0]   sbaddress_o,
    output logic                    sbaddress_update_o,
    output logic [DATA_WIDTH-1:0]   sbdata_o,
    output logic                    sbdata_valid_o,
    output logic                    sbbusy_o,
    output logic                    sbbusyerror_o,
    output logic [2:0]              sberror_o,
    output logic                    req_o,
    input  logic                    gnt_i,
    output logic                    we_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] be_o,
    output logic [2:0]              size_o,
    input  logic                    rvalid_i,
    input  logic [DATA_WIDTH-1:0]   rdata_i,
    input  logic                    rerr_i
);

    localparam int         BE_W     = DATA_WIDTH / 8;
    localparam int         OFF_W    = $clog2(BE_W);
    localparam int         CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0] MAX_SIZE = sba_max_size(DATA_WIDTH);

    sba_state_e              state_r;
    logic                    stale_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    sbbusy_r;
    logic                    sbbusyerror_r;
    logic [2:0]              sberror_r;
    logic [ADDR_WIDTH-1:0]   sbaddress_r;
    logic                    sbaddress_update_r;
    logic [DATA_WIDTH-1:0]   sbdata_r;
    logic                    sbdata_valid_r;
    logic                    req_r;
    logic                    we_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [BE_W-1:0]         be_r;
    logic [2:0]              size_r;

    logic                    trig_any_s;
    logic                    launch_s;
    logic                    misalign_s;
    logic [BE_W-1:0]         be_s;
    logic [DATA_WIDTH-1:0]   wdata_rep_s;
    logic [DATA_WIDTH-1:0]   rdata_aligned_s;

    assign trig_any_s = sbdata_write_valid_i
                      | (sbaddress_write_valid_i & sbreadonaddr_i)
                      | (sbdata_read_valid_i & sbreadondata_i);
    // Triggers are only honoured from a clean idle state.
    assign launch_s   = (state_r == SBA_IDLE) & trig_any_s & (sberror_r == SBERR_NONE)
                      & ~sbbusyerror_r & ~stale_r;
    assign misalign_s = (sbaddress_i & ~({ADDR_WIDTH{1'b1}} << sbaccess_i)) != '0;

    sba_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_align (
        .req_off_i  (sbaddress_i[OFF_W-1:0]),
        .req_size_i (sbaccess_i),
        .wdata_i    (sbdata_i),
        .be_o       (be_s),
        .wdata_o    (wdata_rep_s),
        .rsp_off_i  (addr_r[OFF_W-1:0]),
        .rsp_size_i (size_r),
        .rdata_i    (rdata_i),
        .rdata_o    (rdata_aligned_s)
    );

    // Access FSM with timeout counter, sticky error flags and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r            <= SBA_IDLE;
            stale_r            <= 1'b0;
            cnt_r              <= '0;
            sbbusy_r           <= 1'b0;
            sbbusyerror_r      <= 1'b0;
            sberror_r          <= SBERR_NONE;
            sbaddress_r        <= '0;
            sbaddress_update_r <= 1'b0;
            sbdata_r           <= '0;
            sbdata_valid_r     <= 1'b0;
            req_r              <= 1'b0;
            we_r               <= 1'b0;
            addr_r             <= '0;
            wdata_r            <= '0;
            be_r               <= '0;
            size_r             <= 3'd0;
        end else if (!dmactive_i) begin
            // An abandoned in-flight access still owes a response; mark it stale.
            stale_r            <= (state_r == SBA_WAIT) ? 1'b1 : stale_r;
            state_r            <= SBA_IDLE;
            cnt_r              <= '0;
            sbbusy_r           <= 1'b0;
            sbbusyerror_r      <= 1'b0;
            sberror_r          <= SBERR_NONE;
            sbaddress_r        <= '0;
            sbaddress_update_r <= 1'b0;
            sbdata_r           <= '0;
            sbdata_valid_r     <= 1'b0;
            req_r              <= 1'b0;
            we_r               <= 1'b0;
            addr_r             <= '0;
            wdata_r            <= '0;
            be_r               <= '0;
            size_r             <= 3'd0;
        end else begin
            sbdata_valid_r     <= 1'b0;
            sbaddress_update_r <= 1'b0;
            // Clears first; any error raised below in the same cycle overrides.
            sberror_r          <= sberror_r & ~sberror_clear_i;
            sbbusyerror_r      <= sbbusyerror_r & ~sbbusyerror_clear_i;
            if (sbbusy_r && trig_any_s) begin
                sbbusyerror_r <= 1'b1;
            end
            case (state_r)
                SBA_IDLE: begin
                    cnt_r <= '0;
                    if (stale_r && rvalid_i) begin
                        stale_r <= 1'b0;
                    end
                    if (launch_s) begin
                        if (sbaccess_i > MAX_SIZE) begin
                            sberror_r <= SBERR_SIZE;
                        end else if (misalign_s) begin
                            sberror_r <= SBERR_ALIGN;
                        end else begin
                            addr_r   <= sbaddress_i;
                            size_r   <= sbaccess_i;
                            we_r     <= sbdata_write_valid_i;
                            wdata_r  <= wdata_rep_s;
                            be_r     <= be_s;
                            req_r    <= 1'b1;
                            sbbusy_r <= 1'b1;
                            state_r  <= SBA_REQ;
                        end
                    end
                end
                SBA_REQ: begin
                    if (gnt_i) begin
                        req_r   <= 1'b0;
                        cnt_r   <= '0;
                        state_r <= SBA_WAIT;
                    end
                end
                SBA_WAIT: begin
                    if (rvalid_i) begin
                        state_r  <= SBA_IDLE;
                        sbbusy_r <= 1'b0;
                        cnt_r    <= '0;
                        if (rerr_i) begin
                            sberror_r <= SBERR_BADADDR;
                        end else begin
                            if (!we_r) begin
                                sbdata_r       <= rdata_aligned_s;
                                sbdata_valid_r <= 1'b1;
                            end
                            if (sbautoincrement_i) begin
                                sbaddress_r        <= addr_r + (ADDR_WIDTH'(1) << size_r);
                                sbaddress_update_r <= 1'b1;
                            end
                        end
                    end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        sberror_r <= SBERR_TIMEOUT;
                        stale_r   <= 1'b1;
                        state_r   <= SBA_IDLE;
                        sbbusy_r  <= 1'b0;
                        cnt_r     <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r  <= SBA_IDLE;
                    sbbusy_r <= 1'b0;
                    req_r    <= 1'b0;
                    cnt_r    <= '0;
                end
            endcase
        end
    end

    assign sbaddress_o        = sbaddress_r;
    assign sbaddress_update_o = sbaddress_update_r;
    assign sbdata_o           = sbdata_r;
    assign sbdata_valid_o     = sbdata_valid_r;
    assign sbbusy_o           = sbbusy_r;
    assign sbbusyerror_o      = sbbusyerror_r;
    assign sberror_o          = sberror_r;
    assign req_o              = req_r;
    assign we_o               = we_r;
    assign addr_o             = addr_r;
    assign wdata_o            = wdata_r;
    assign be_o               = be_r;
    assign size_o             = size_r;

endmodule

// File: tb/tb_sba_bus_master.sv
// Directed self-checking bench for sba_bus_master (64-bit data, 32-bit address,
// 8-cycle timeout).
module tb_sba_bus_master;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        dmactive_i;
    logic [31:0] sbaddress_i;
    logic        sbaddress_write_valid_i;
    logic        sbreadonaddr_i;
    logic        sbreadondata_i;
    logic        sbautoincrement_i;
    logic [2:0]  sbaccess_i;
    logic [63:0] sbdata_i;
    logic        sbdata_write_valid_i;
    logic        sbdata_read_valid_i;
    logic [2:0]  sberror_clear_i;
    logic        sbbusyerror_clear_i;
    logic [31:0] sbaddress_o;
    logic        sbaddress_update_o;
    logic [63:0] sbdata_o;
    logic        sbdata_valid_o;
    logic        sbbusy_o;
    logic        sbbusyerror_o;
    logic [2:0]  sberror_o;
    logic        req_o;
    logic        gnt_i;
    logic        we_o;
    logic [31:0] addr_o;
    logic [63:0] wdata_o;
    logic [7:0]  be_o;
    logic [2:0]  size_o;
    logic        rvalid_i;
    logic [63:0] rdata_i;
    logic        rerr_i;

    int n_cmp = 0;
    int n_err = 0;

    sba_bus_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (64),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i                   (clk_i),
        .rst_ni                  (rst_ni),
        .dmactive_i              (dmactive_i),
        .sbaddress_i             (sbaddress_i),
        .sbaddress_write_valid_i (sbaddress_write_valid_i),
        .sbreadonaddr_i          (sbreadonaddr_i),
        .sbreadondata_i          (sbreadondata_i),
        .sbautoincrement_i       (sbautoincrement_i),
        .sbaccess_i              (sbaccess_i),
        .sbdata_i                (sbdata_i),
        .sbdata_write_valid_i    (sbdata_write_valid_i),
        .sbdata_read_valid_i     (sbdata_read_valid_i),
        .sberror_clear_i         (sberror_clear_i),
        .sbbusyerror_clear_i     (sbbusyerror_clear_i),
        .sbaddress_o             (sbaddress_o),
        .sbaddress_update_o      (sbaddress_update_o),
        .sbdata_o                (sbdata_o),
        .sbdata_valid_o          (sbdata_valid_o),
        .sbbusy_o                (sbbusy_o),
        .sbbusyerror_o           (sbbusyerror_o),
        .sberror_o               (sberror_o),
        .req_o                   (req_o),
        .gnt_i                   (gnt_i),
        .we_o                    (we_o),
        .addr_o                  (addr_o),
        .wdata_o                 (wdata_o),
        .be_o                    (be_o),
        .size_o                  (size_o),
        .rvalid_i                (rvalid_i),
        .rdata_i                 (rdata_i),
        .rerr_i                  (rerr_i)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_i);
    endtask

    // Read triggered by an sbaddress write, zero-wait grant, response right after.
    task automatic read_txn(input string tag, input logic [31:0] a, input logic [2:0] sz,
                            input logic [63:0] rd, input logic [7:0] exp_be,
                            input logic [63:0] exp_d);
        sbaddress_i = a; sbaccess_i = sz; sbreadonaddr_i = 1'b1; sbaddress_write_valid_i = 1'b1;
        cyc();
        sbaddress_write_valid_i = 1'b0;
        check_eq({tag, "_req"}, req_o, 1'b1);
        check_eq({tag, "_we"}, we_o, 1'b0);
        check_eq({tag, "_be"}, be_o, exp_be);
        cyc();
        rvalid_i = 1'b1; rdata_i = rd;
        cyc();
        rvalid_i = 1'b0;
        check_eq({tag, "_valid"}, sbdata_valid_o, 1'b1);
        check_eq({tag, "_data"}, sbdata_o, exp_d);
        cyc();
        check_eq({tag, "_pulse"}, sbdata_valid_o, 1'b0);
    endtask

    task automatic clear_errors();
        sberror_clear_i = 3'd7;
        cyc();
        sberror_clear_i = 3'd0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0; dmactive_i = 1'b1;
        sbaddress_i = 32'd0; sbaddress_write_valid_i = 1'b0;
        sbreadonaddr_i = 1'b0; sbreadondata_i = 1'b0; sbautoincrement_i = 1'b0;
        sbaccess_i = 3'd0; sbdata_i = 64'd0;
        sbdata_write_valid_i = 1'b0; sbdata_read_valid_i = 1'b0;
        sberror_clear_i = 3'd0; sbbusyerror_clear_i = 1'b0;
        gnt_i = 1'b1; rvalid_i = 1'b0; rdata_i = 64'd0; rerr_i = 1'b0;
        cyc(); cyc();
        check_eq("rst_req", req_o, 1'b0);
        check_eq("rst_busy", sbbusy_o, 1'b0);
        check_eq("rst_err", sberror_o, 3'd0);
        check_eq("rst_addr", addr_o, 32'd0);
        check_eq("rst_be", be_o, 8'd0);
        rst_ni = 1'b1;
        cyc();

        // 16-bit write at offset 6 with autoincrement.
        sbaccess_i = 3'd1; sbaddress_i = 32'h1006; sbdata_i = 64'hABCD;
        sbautoincrement_i = 1'b1; sbdata_write_valid_i = 1'b1;
        cyc();
        sbdata_write_valid_i = 1'b0;
        check_eq("wr_req", req_o, 1'b1);
        check_eq("wr_we", we_o, 1'b1);
        check_eq("wr_be", be_o, 8'hC0);
        check_eq("wr_wdata", wdata_o, 64'hABCD_ABCD_ABCD_ABCD);
        check_eq("wr_addr", addr_o, 32'h1006);
        check_eq("wr_size", size_o, 3'd1);
        check_eq("wr_busy", sbbusy_o, 1'b1);
        cyc();
        check_eq("wr_req_drop", req_o, 1'b0);
        rvalid_i = 1'b1;
        cyc();
        rvalid_i = 1'b0;
        check_eq("wr_upd", sbaddress_update_o, 1'b1);
        check_eq("wr_incaddr", sbaddress_o, 32'h1008);
        check_eq("wr_nodata", sbdata_valid_o, 1'b0);
        check_eq("wr_idle", sbbusy_o, 1'b0);
        cyc();
        check_eq("wr_upd_pulse", sbaddress_update_o, 1'b0);
        sbautoincrement_i = 1'b0;

        // Reads of several sizes and offsets.
        read_txn("rd_b3", 32'h3,  3'd0, 64'h1122_3344,          8'h08, 64'h11);
        read_txn("rd_h2", 32'h2,  3'd1, 64'h8877_6655_4433_2211, 8'h0C, 64'h4433);
        read_txn("rd_w4", 32'h14, 3'd2, 64'h8877_6655_4433_2211, 8'hF0, 64'h8877_6655);
        read_txn("rd_d",  32'h10, 3'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF);

        // Size error, then alignment error, each cleared.
        sbaccess_i = 3'd4; sbaddress_i = 32'h0; sbdata_write_valid_i = 1'b1;
        cyc();
        sbdata_write_valid_i = 1'b0;
        check_eq("size_err", sberror_o, 3'd4);
        check_eq("size_noreq", req_o, 1'b0);
        clear_errors();
        check_eq("size_clr", sberror_o, 3'd0);
        sbaccess_i = 3'd2; sbaddress_i = 32'h2; sbdata_write_valid_i = 1'b1;
        cyc();
        sbdata_write_valid_i = 1'b0;
        check_eq("align_err", sberror_o, 3'd3);
        check_eq("align_noreq", req_o, 1'b0);
        clear_errors();
        check_eq("align_clr", sberror_o, 3'd0);

        // Bus error response: no data strobe, no increment.
        sbautoincrement_i = 1'b1;
        sbaddress_i = 32'h8; sbaccess_i = 3'd3; sbreadonaddr_i = 1'b1; sbaddress_write_valid_i = 1'b1;
        cyc();
        sbaddress_write_valid_i = 1'b0;
        cyc();
        rvalid_i = 1'b1; rerr_i = 1'b1;
        cyc();
        rvalid_i = 1'b0; rerr_i = 1'b0;
        check_eq("berr_code", sberror_o, 3'd2);
        check_eq("berr_nodata", sbdata_valid_o, 1'b0);
        check_eq("berr_noinc", sbaddress_update_o, 1'b0);
        clear_errors();
        sbautoincrement_i = 1'b0;

        // Timeout after 8 WAIT cycles, stale response discarded.
        sbaddress_i = 32'h20; sbaccess_i = 3'd3; sbaddress_write_valid_i = 1'b1;
        cyc();
        sbaddress_write_valid_i = 1'b0;
        check_eq("to_req", req_o, 1'b1);
        for (int i = 0; i < 8; i++) cyc();
        check_eq("to_busy_before", sbbusy_o, 1'b1);
        check_eq("to_err_before", sberror_o, 3'd0);
        cyc();
        check_eq("to_err", sberror_o, 3'd1);
        check_eq("to_idle", sbbusy_o, 1'b0);
        clear_errors();
        check_eq("to_clr", sberror_o, 3'd0);
        sbaddress_write_valid_i = 1'b1;
        cyc();
        sbaddress_write_valid_i = 1'b0;
        check_eq("stale_block", req_o, 1'b0);
        rvalid_i = 1'b1; rdata_i = 64'hDEAD;
        cyc();
        rvalid_i = 1'b0;
        check_eq("stale_drop", sbdata_valid_o, 1'b0);
        read_txn("rd_after_to", 32'h20, 3'd3, 64'h1122_3344_5566_7788, 8'hFF, 64'h1122_3344_5566_7788);

        // Stalled grant, then busy error from a second write during WAIT.
        gnt_i = 1'b0; sbaddress_i = 32'h40; sbaccess_i = 3'd0; sbdata_i = 64'h5A;
        sbdata_write_valid_i = 1'b1;
        cyc();
        sbdata_write_valid_i = 1'b0;
        check_eq("stall_req", req_o, 1'b1);
        check_eq("stall_wdata", wdata_o, 64'h5A5A_5A5A_5A5A_5A5A);
        check_eq("stall_be", be_o, 8'h01);
        cyc();
        check_eq("stall_hold_req", req_o, 1'b1);
        check_eq("stall_hold_addr", addr_o, 32'h40);
        gnt_i = 1'b1;
        cyc();
        check_eq("busy_req_drop", req_o, 1'b0);
        sbdata_write_valid_i = 1'b1;
        cyc();
        sbdata_write_valid_i = 1'b0;
        check_eq("busyerr_set", sbbusyerror_o, 1'b1);
        check_eq("busyerr_noreq", req_o, 1'b0);
        rvalid_i = 1'b1;
        cyc();
        rvalid_i = 1'b0;
        check_eq("busyerr_done", sbbusy_o, 1'b0);
        check_eq("busyerr_sticky", sbbusyerror_o, 1'b1);
        sbaddress_write_valid_i = 1'b1;
        cyc();
        sbaddress_write_valid_i = 1'b0;
        check_eq("busyerr_block", req_o, 1'b0);
        sbbusyerror_clear_i = 1'b1;
        cyc();
        sbbusyerror_clear_i = 1'b0;
        check_eq("busyerr_clr", sbbusyerror_o, 1'b0);

        // Soft reset during WAIT drops the pending response.
        sbaddress_i = 32'h80; sbaccess_i = 3'd3; sbaddress_write_valid_i = 1'b1;
        cyc();
        sbaddress_write_valid_i = 1'b0;
        cyc();
        dmactive_i = 1'b0;
        cyc();
        dmactive_i = 1'b1;
        check_eq("dm_idle", sbbusy_o, 1'b0);
        check_eq("dm_addr", addr_o, 32'd0);
        rvalid_i = 1'b1; rdata_i = 64'hBAD;
        cyc();
        rvalid_i = 1'b0;
        check_eq("dm_drop", sbdata_valid_o, 1'b0);
        read_txn("rd_after_dm", 32'h88, 3'd3, 64'hCAFE_F00D_1234_5678, 8'hFF, 64'hCAFE_F00D_1234_5678);

        // Asynchronous reset while requesting.
        gnt_i = 1'b0; sbaddress_i = 32'h100; sbaccess_i = 3'd2; sbdata_write_valid_i = 1'b1;
        cyc();
        sbdata_write_valid_i = 1'b0;
        check_eq("ar_req", req_o, 1'b1);
        #1 rst_ni = 1'b0;
        #1;
        check_eq("ar_req0", req_o, 1'b0);
        check_eq("ar_busy0", sbbusy_o, 1'b0);
        check_eq("ar_be0", be_o, 8'd0);
        check_eq("ar_wdata0", wdata_o, 64'd0);
        cyc();
        rst_ni = 1'b1; gnt_i = 1'b1;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sba_bus_master.md
# sba_bus_master

Parametrised system-bus-access master for the debug module. It turns debugger SBA commands into single-beat transactions on a generic request/grant/response memory port. Relative to the first-generation SBA block, it adds configurable address and data width, access sizes up to the full bus width, byte-lane alignment of read and write data, and a response timeout. It also reports the full debug-spec error set: sticky `sberror` codes, sticky `sbbusyerror`, and write-1-to-clear.

## Interface
- `ADDR_WIDTH`, default 64: bus/sbaddress width.
- `DATA_WIDTH`, default 64: bus data width; legal values 32, 64, 128.
- `TIMEOUT_CYCLES`, default 1024: maximum cycles from grant to response; must be ≥ 2.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `dmactive_i` in 1: synchronous soft reset, active low.
- `sbaddress_i` in ADDR_WIDTH: current sbaddress.
- `sbaddress_write_valid_i` in 1: debugger wrote sbaddress.
- `sbreadonaddr_i`, `sbreadondata_i`, `sbautoincrement_i` in 1: sbcs control bits.
- `sbaccess_i` in 3: log2 of access size in bytes.
- `sbdata_i` in DATA_WIDTH: write data.
- `sbdata_write_valid_i`, `sbdata_read_valid_i` in 1: debugger wrote / read sbdata0.
- `sberror_clear_i` in 3: write-1-to-clear mask for `sberror_o`.
- `sbbusyerror_clear_i` in 1: clears `sbbusyerror_o`.
- `sbaddress_o` out ADDR_WIDTH: incremented address.
- `sbaddress_update_o` out 1: one-cycle strobe; load `sbaddress_o`.
- `sbdata_o` out DATA_WIDTH: read data, right-aligned and zero-extended.
- `sbdata_valid_o` out 1: one-cycle strobe for `sbdata_o`.
- `sbbusy_o`, `sbbusyerror_o` out 1: busy flag and sticky busy error.
- `sberror_o` out 3: sticky error code.
- `req_o` out 1, `gnt_i` in 1: bus request and grant.
- `we_o` out 1: write enable.
- `addr_o` out ADDR_WIDTH: bus address.
- `wdata_o` out DATA_WIDTH: bus write data.
- `be_o` out DATA_WIDTH/8: byte enables.
- `size_o` out 3: access size.
- `rvalid_i` in 1, `rdata_i` in DATA_WIDTH, `rerr_i` in 1: bus response.

## Operation
- **States:** IDLE, REQ, WAIT.
- **Triggers:** only evaluated in IDLE, and only when `sberror_o`=0, `sbbusyerror_o`=0 and `stale`=0. Priority:
  1. `sbdata_write_valid_i` → write.
  2. `sbaddress_write_valid_i` && `sbreadonaddr_i` → read.
  3. `sbdata_read_valid_i` && `sbreadondata_i` → read.
- **Busy error:** a trigger raised while `sbbusy_o`=1 sets `sbbusyerror_o` and is otherwise ignored.
- **Launch checks (IDLE, in this order):**
  - If `sbaccess_i` > log2(DATA_WIDTH/8): `sberror_o`=4, stay IDLE.
  - Else if address is misaligned to the access size: `sberror_o`=3, stay IDLE.
  - Else latch addr, size, we and wdata, and go to REQ.
- **REQ:** `req_o`=1, with all request fields held stable until `gnt_i`; on grant go to WAIT.
- **WAIT:** the timeout counter runs.
  - `rvalid_i` && !`rerr_i`: complete the access.
    - Reads pulse `sbdata_valid_o`.
    - If `sbautoincrement_i`, pulse `sbaddress_update_o` with `sbaddress_o` = addr + (1<<size), wrapping modulo 2^ADDR_WIDTH.
    - Return to IDLE.
  - `rvalid_i` && `rerr_i`: `sberror_o`=2, no data strobe, no increment, IDLE.
  - Counter reaches TIMEOUT_CYCLES with no response: `sberror_o`=1, set `stale`, IDLE.
- **Stale response:** the bus returns exactly one response per grant. When `stale` is set, the next `rvalid_i` is discarded and clears `stale`.
- **Lane alignment:**
  - `be_o` has 2^size consecutive ones at the byte offset given by `addr[log2(DATA_WIDTH/8)-1:0]`.
  - `wdata_o` is the low 2^size bytes of `sbdata_i` replicated across all lanes.
  - `sbdata_o` is `rdata_i` shifted down by the byte offset and masked to 2^size bytes.
- **Error clearing:** `sberror_o` bits are cleared where `sberror_clear_i` bits are 1. A new error set in the same cycle as a clear wins.
- **`dmactive_i`=0:** state returns to IDLE, errors and strobes are cleared, and outputs return to reset values. `stale` is set if the state was WAIT; otherwise it is kept.

## Timing
- Reset values: state IDLE, `stale`=0, counter 0, every output 0.
- `sbbusy_o` = (state != IDLE), registered.
- Trigger at cycle T → `req_o` high at T+1.
- Zero-wait grant at T+1 → WAIT at T+2.
- The earliest `rvalid_i` is accepted at T+2; `sbdata_valid_o` and `sbaddress_update_o` pulse at T+3, and the state is IDLE at T+3.
- A trigger accepted in the same cycle as completion is a busy error. A trigger one cycle after completion starts normally.
- The timeout fires on the TIMEOUT_CYCLES-th WAIT cycle without a response.

## Structure
- Package `sba_pkg` holds:
  - `sba_state_e`.
  - Error constants: `SBERR_NONE`=0, `SBERR_TIMEOUT`=1, `SBERR_BADADDR`=2, `SBERR_ALIGN`=3, `SBERR_SIZE`=4.
  - Function `sba_max_size(DATA_WIDTH)`.
- Sub-module `sba_lane_align` (combinational): be generation, wdata replication, rdata extraction.
- FSM, counter and sticky flags live in the top module.

## Test plan
- **64-bit write:** DATA_WIDTH=64, sbaccess=1, addr 0x1006, sbdata 0xABCD → `be_o`=0xC0, `wdata_o`=0xABCD_ABCD_ABCD_ABCD; with autoincrement, `sbaddress_o`=0x1008.
- **Read on addr, 32-bit bus:** sbaccess=0, addr 0x3, `rdata_i`=0x11223344 → `sbdata_o`=0x11, `sbdata_valid_o` one cycle at T+3.
- **Error codes:** sbaccess=4 on DATA_WIDTH=64 → `sberror_o`=4, no `req_o`. Addr 0x2 with sbaccess=2 → `sberror_o`=3. `sberror_clear_i`=7 → 0.
- **Timeout:** TIMEOUT_CYCLES=8, no `rvalid_i` → `sberror_o`=1 after 8 WAIT cycles. A late response is discarded. After clear, the next read completes with correct data.
- **Busy error:** second sbdata write during WAIT → `sbbusyerror_o`=1, single bus transaction. Further triggers are ignored until `sbbusyerror_clear_i`.
- **Reset and soft reset:** `rst_ni` low during REQ → all outputs 0 immediately. `dmactive_i` low during WAIT → IDLE and `stale`=1, and the pending response is dropped.
